sa_feed_controller: RTL and testbench

Parametrised successor to the systolic-array input controller. It drains COL column FIFOs into the array edge in bursts of a runtime-programmable number of beats, and inserts a programmable number of zero bubble cycles between beats. When any column FIFO is empty it stalls and raises a flag instead of feeding stale data. A start/busy/done handshake lets the array sequencer launch one burst per tile.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_feed_controller.sv | 102 ++++++++++
 tb/tb_sa_feed_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array feed controller.
package sa_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sa_state_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sa_feed_controller.sv
// Drains COL column FIFOs into the array edge in bursts of rows_q beats,
// with gap_q bubble cycles after each beat and a stall on any empty FIFO.
//
// state | meaning
// IDLE  | waiting for i_start; rows/gap latched on acceptance
// FEED  | read slot: read all columns unless one is empty (stall)
// GAP   | gap_q bubble cycles between beats
// DRAIN | last beat's data leaves the output register
// DONE  | one-cycle completion pulse
module sa_feed_controller
  import sa_pkg::*;
#(
  parameter int COL      = 64,
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_ROWS = 255,
  parameter int MAX_GAP  = 15
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [cnt_width(MAX_ROWS)-1:0]       i_rows,
  input  logic [cnt_width(MAX_GAP)-1:0]        i_gap,
  input  logic [COL*DW-1:0]                    i_data,
  input  logic [COL-1:0]                       i_fifo_empty,
  output logic [COL-1:0]                       o_fifo_read_enable,
  output logic                                 o_select,
  output logic                                 o_valid,
  output logic [COL*DW-1:0]                    o_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_stall
);

  localparam int RW = cnt_width(MAX_ROWS);
  localparam int GW = cnt_width(MAX_GAP);

  sa_state_t     state;
  logic [RW-1:0] rows_q;
  logic [RW-1:0] beat_cnt;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_cnt;
  logic          valid_q;
  logic          rd;

  // A read happens only in a FEED slot where every column has data.
  assign rd = (state == ST_FEED) && !(|i_fifo_empty);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      rows_q   <= '0;
      gap_q    <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= rd;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rows_q   <= i_rows;
            gap_q    <= i_gap;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            state    <= (i_rows == '0) ? ST_DONE : ST_FEED;
          end
        end
        ST_FEED: begin
          if (rd) begin
            beat_cnt <= beat_cnt + RW'(1);
            if (beat_cnt + RW'(1) == rows_q) begin
              state <= ST_DRAIN;
            end else if (gap_q != '0) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap_q - GW'(1)) begin
            gap_cnt <= '0;
            state   <= ST_FEED;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_read_enable = {COL{rd}};
  assign o_stall            = (state == ST_FEED) && (|i_fifo_empty);
  assign o_valid            = valid_q;
  assign o_data             = valid_q ? i_data : '0;
  assign o_select           = (state == ST_FEED) || (state == ST_GAP) || (state == ST_DRAIN);
  assign o_busy             = (state != ST_IDLE);
  assign o_done             = (state == ST_DONE);

endmodule

// File: tb/tb_sa_feed_controller.sv
// Directed and randomized bursts checked against a cycle-schedule model of the feed controller.
module tb_sa_feed_controller;

  localparam int COL  = 8;
  localparam int DW   = 16;
  localparam int DALL = COL * DW;
  localparam int NCYC = 256;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic [7:0]        i_rows;
  logic [3:0]        i_gap;
  logic [DALL-1:0]   i_data;
  logic [COL-1:0]    i_fifo_empty;
  logic [COL-1:0]    o_fifo_read_enable;
  logic              o_select;
  logic              o_valid;
  logic [DALL-1:0]   o_data;
  logic              o_busy;
  logic              o_done;
  logic              o_stall;

  int n_checks = 0;
  int n_fails  = 0;

  bit e_rd[NCYC], e_valid[NCYC], e_sel[NCYC], e_busy[NCYC], e_done[NCYC], e_stall[NCYC];

  sa_feed_controller #(.COL(COL), .DW(DW), .MAX_ROWS(255), .MAX_GAP(15)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_start            (i_start),
    .i_rows             (i_rows),
    .i_gap              (i_gap),
    .i_data             (i_data),
    .i_fifo_empty       (i_fifo_empty),
    .o_fifo_read_enable (o_fifo_read_enable),
    .o_select           (o_select),
    .o_valid            (o_valid),
    .o_data             (o_data),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_stall            (o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int cyc, input logic [DALL-1:0] obs,
                     input logic [DALL-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Schedule model: beats start at cycle 1, each read slot slips while the
  // empty window covers it, then the next slot is gap+1 cycles later.
  task automatic run_burst(input int rows, input int gap, input int ecol, input int elo,
                           input int ehi, input bit poke, input int rst_cyc);
    int t, drain_c, done_c, end_c;
    logic [DALL-1:0] d;
    for (int c = 0; c < NCYC; c++) begin
      e_rd[c] = 0; e_valid[c] = 0; e_sel[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_stall[c] = 0;
    end
    if (rows == 0) begin
      done_c = 1;
      drain_c = 0;
    end else begin
      t = 1;
      for (int b = 0; b < rows; b++) begin
        while (t >= elo && t <= ehi) begin
          e_stall[t] = 1;
          t++;
        end
        e_rd[t] = 1;
        e_valid[t+1] = 1;
        if (b != rows - 1) t += gap + 1;
      end
      drain_c = t + 1;
      done_c  = t + 2;
      for (int c = 1; c <= drain_c; c++) e_sel[c] = 1;
    end
    for (int c = 1; c <= done_c; c++) e_busy[c] = 1;
    e_done[done_c] = 1;
    end_c = done_c + 1;
    if (rst_cyc >= 0 && rst_cyc < end_c) begin
      end_c = rst_cyc + 3;
      for (int c = rst_cyc + 1; c < NCYC; c++) begin
        e_rd[c] = 0; e_valid[c] = 0; e_sel[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_stall[c] = 0;
      end
    end

    for (int c = 0; c <= end_c; c++) begin
      i_rst_n = (c != rst_cyc);
      i_start = (c == 0) || (poke && c == 4);
      if (c == 0) begin
        i_rows = 8'(rows);
        i_gap  = 4'(gap);
      end else if (poke && c == 4) begin
        i_rows = 8'd2;
        i_gap  = 4'(gap + 2);
      end
      i_fifo_empty = '0;
      if (c >= elo && c <= ehi) i_fifo_empty[ecol] = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      i_data = d;
      #4;
      chk("read_enable", c, DALL'(o_fifo_read_enable), DALL'({COL{e_rd[c]}}));
      chk("valid",  c, DALL'(o_valid),  DALL'(e_valid[c]));
      chk("data",   c, o_data, e_valid[c] ? d : '0);
      chk("select", c, DALL'(o_select), DALL'(e_sel[c]));
      chk("busy",   c, DALL'(o_busy),   DALL'(e_busy[c]));
      chk("done",   c, DALL'(o_done),   DALL'(e_done[c]));
      chk("stall",  c, DALL'(o_stall),  DALL'(e_stall[c]));
      @(posedge i_clk);
      #1;
    end
    i_start = 0;
    i_rst_n = 1;
  endtask

  initial begin
    int r, g, ec, lo, ln;
    i_rst_n = 0; i_start = 0; i_rows = '0; i_gap = '0; i_data = '0; i_fifo_empty = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_read_enable", 0, DALL'(o_fifo_read_enable), '0);
    chk("rst_select", 0, DALL'(o_select), '0);
    chk("rst_valid",  0, DALL'(o_valid),  '0);
    chk("rst_data",   0, o_data, '0);
    chk("rst_busy",   0, DALL'(o_busy),   '0);
    chk("rst_done",   0, DALL'(o_done),   '0);
    chk("rst_stall",  0, DALL'(o_stall),  '0);
    i_rst_n = 1;
    @(posedge i_clk);
    #1;

    run_burst(9, 1, 0, -1, -2, 0, -1);
    run_burst(4, 0, 0, -1, -2, 0, -1);
    run_burst(3, 1, 5, 3, 4, 0, -1);
    run_burst(0, 2, 0, -1, -2, 0, -1);
    run_burst(9, 1, 0, -1, -2, 1, -1);
    run_burst(9, 1, 0, -1, -2, 0, 6);
    run_burst(9, 1, 0, -1, -2, 0, -1);
    run_burst(3, 2, 2, 2, 3, 0, -1);
    run_burst(1, 0, 0, -1, -2, 0, -1);

    for (int k = 0; k < 8; k++) begin
      r  = $urandom_range(12, 1);
      g  = $urandom_range(3, 0);
      ec = $urandom_range(COL - 1, 0);
      lo = $urandom_range(15, 1);
      ln = $urandom_range(5, 0);
      run_burst(r, g, ec, lo, lo + ln - 1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
